// File: rtl/regfile_wr_arb_pkg.sv
// Shared register-file types and widths for the write-port arbiter.
// Late-result FIFO entry layout and address decode helper.
package regfile_wr_arb_pkg;
  localparam int RegBusW    = 32;
  localparam int RegAddrW   = 5;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;
  localparam int LtFifoDepth = 2;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic [RegBusW-1:0] ZeroWord = '0;

  typedef logic [RegBusW-1:0]  reg_t;
  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [RegNum-1:0]   reg_mask_t;

  typedef struct packed {
    logic      live;
    reg_addr_t addr;
    reg_t      data;
  } lt_ent_t;

  function automatic reg_mask_t addr_dec(reg_addr_t a);
    addr_dec    = '0;
    addr_dec[a] = 1'b1;
  endfunction
endpackage

// File: rtl/regfile_wr_arb_if.sv
// Late-unit result handshake into the write-port arbiter.
// Transfer occurs when lt_valid && lt_ready.
interface regfile_wr_arb_if;
  import regfile_wr_arb_pkg::*;

  logic      lt_valid;
  logic      lt_ready;
  reg_addr_t lt_waddr;
  reg_t      lt_wdata;

  modport master (
    output lt_valid, lt_waddr, lt_wdata,
    input  lt_ready
  );

  modport slave (
    input  lt_valid, lt_waddr, lt_wdata,
    output lt_ready
  );
endinterface

// File: rtl/regfile_wr_arb_fifo.sv
// Late-result FIFO with per-entry live bits and address-match kill.
// Occupancy counts 0..DEPTH so full/empty never alias.
module wr_arb_fifo
  import regfile_wr_arb_pkg::*;
#(
  parameter int DEPTH = LtFifoDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  lt_ent_t          push_ent,
  input  logic             kill_en,
  input  reg_addr_t        kill_addr,
  input  logic             pop,
  output lt_ent_t          head,
  output logic             empty,
  output logic             full,
  output logic [DEPTH-1:0] live,
  output reg_addr_t        addr [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  lt_ent_t        mem_q [DEPTH];
  lt_ent_t        mem_d [DEPTH];
  logic [PW-1:0]  rd_q, rd_d;
  logic [PW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && mem_q[i].addr == kill_addr)
        mem_d[i].live = 1'b0;
    end
    // Popped slots go dead so only occupied entries can be live.
    if (pop)  mem_d[rd_q].live = 1'b0;
    if (push) mem_d[wr_q] = push_ent;
    rd_d  = rd_q + PW'(pop);
    wr_d  = wr_q + PW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i].live <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    head  = mem_q[rd_q];
    empty = (cnt_q == '0);
    full  = (cnt_q == CW'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = mem_q[i].live;
      addr[i] = mem_q[i].addr;
    end
  end
endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: pipeline write-back has priority,
// late results drain from a FIFO into idle slots.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int DEPTH        = LtFifoDepth,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  reg_addr_t        wb_waddr,
  input  reg_t             wb_wdata,
  regfile_wr_arb_if.slave  lt,
  output logic             we,
  output reg_addr_t        waddr,
  output reg_t             wdata,
  output reg_mask_t        pend_mask,
  output logic             stall_req
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic             push, pop;
  logic             empty, full;
  logic             head_live;
  lt_ent_t          push_ent, head;
  logic [DEPTH-1:0] live;
  reg_addr_t        addr [DEPTH];
  logic [SW-1:0]    starve_q, starve_d;
  logic             run;

  wr_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_ent  (push_ent),
    .kill_en   (wb_we),
    .kill_addr (wb_waddr),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .live      (live),
    .addr      (addr)
  );

  always_comb begin
    run         = (rst != RstEnable);
    lt.lt_ready = run && !full;
    push        = lt.lt_valid && lt.lt_ready;
    // A same-cycle pipeline write to the same register is younger.
    push_ent.addr = lt.lt_waddr;
    push_ent.data = lt.lt_wdata;
    push_ent.live = (lt.lt_waddr != '0) &&
                    !(wb_we && wb_waddr == lt.lt_waddr);
    head_live = !empty && head.live;
    pop       = !empty && (!head.live || !wb_we);

    we    = 1'b0;
    waddr = '0;
    wdata = ZeroWord;
    if (run) begin
      if (wb_we) begin
        we    = WriteEnable;
        waddr = wb_waddr;
        wdata = wb_wdata;
      end else if (head_live) begin
        we    = WriteEnable;
        waddr = head.addr;
        wdata = head.data;
      end
    end

    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pend_mask = pend_mask | addr_dec(addr[i]);
    end

    starve_d = starve_q;
    if (pop || empty)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
    stall_req = (starve_q == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) starve_q <= '0;
    else                  starve_q <= starve_d;
  end
endmodule

// File: tb/tb_regfile_wr_arb.sv
// Scoreboard bench for regfile_wr_arb: expected writes queued by
// stimulus, popped by a negedge monitor whenever we is high.
module tb_regfile_wr_arb;
  import regfile_wr_arb_pkg::*;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic      clk = 1'b0;
  logic      rst;
  logic      wb_we;
  reg_addr_t wb_waddr;
  reg_t      wb_wdata;
  logic      we;
  reg_addr_t waddr;
  reg_t      wdata;
  reg_mask_t pend_mask;
  logic      stall_req;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  wr_t exp_q[$];

  regfile_wr_arb_if bus();

  regfile_wr_arb #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .lt        (bus),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_mask (pend_mask),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic late(input logic v, input logic [4:0] a,
                      input logic [31:0] d);
    bus.lt_valid = v;
    bus.lt_waddr = a;
    bus.lt_wdata = d;
  endtask

  task automatic wb(input logic v, input logic [4:0] a,
                    input logic [31:0] d);
    wb_we    = v;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (we === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got r%0d=0x%0h want none",
                 waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (waddr === e.a && wdata === e.d) pass_cnt++;
        else $display("FAIL write: got r%0d=0x%0h want r%0d=0x%0h",
                      waddr, wdata, e.a, e.d);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    late(1'b0, 5'd0, 32'h0);
    step();
    step();
    wb(1'b1, 5'd3, 32'h99);
    #1;
    chk("rst_ready", 64'(bus.lt_ready), 64'd0);
    chk("rst_we_gate", 64'(we), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);

    // pipeline write, first cycle after reset
    rst = 1'b0;
    wb(1'b1, 5'd3, 32'h11);
    expw(5'd3, 32'h11);
    #1;
    chk("ready_after_rst", 64'(bus.lt_ready), 64'd1);
    step();

    // late push with idle pipeline
    wb(1'b0, 5'd0, 32'h0);
    late(1'b1, 5'd5, 32'hAA);
    step();
    late(1'b0, 5'd0, 32'h0);
    expw(5'd5, 32'hAA);
    #1;
    chk("pend5_set", 64'(pend_mask), 64'h20);
    step();
    chk("pend5_clr", 64'(pend_mask), 64'd0);

    // late result superseded by younger pipeline write
    late(1'b1, 5'd7, 32'hBB);
    step();
    late(1'b0, 5'd0, 32'h0);
    wb(1'b1, 5'd7, 32'hCC);
    expw(5'd7, 32'hCC);
    #1;
    chk("pend7_set", 64'(pend_mask), 64'h80);
    step();
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("pend7_killed", 64'(pend_mask), 64'd0);
    step();
    step();

    // starvation under continuous write-back
    for (int c = 0; c < 9; c++) begin
      wb(1'b1, 5'd1, 32'h100 + c);
      expw(5'd1, 32'h100 + c);
      if (c < 2) late(1'b1, 5'(10 + c), 32'hA0 + 32'(c * 16));
      else       late(1'b0, 5'd0, 32'h0);
      if (c == 2) begin
        #1;
        chk("full_not_ready", 64'(bus.lt_ready), 64'd0);
        chk("pend_10_11", 64'(pend_mask), 64'h0C00);
      end
      if (c == 8) begin
        #1;
        chk("stall_not_yet", 64'(stall_req), 64'd0);
      end
      step();
    end
    wb(1'b0, 5'd0, 32'h0);
    expw(5'd10, 32'hA0);
    #1;
    chk("stall_set", 64'(stall_req), 64'd1);
    step();
    expw(5'd11, 32'hB0);
    #1;
    chk("stall_clr", 64'(stall_req), 64'd0);
    step();
    chk("drained_ready", 64'(bus.lt_ready), 64'd1);
    chk("drained_pend", 64'(pend_mask), 64'd0);

    // push to r0: accepted, never written
    late(1'b1, 5'd0, 32'h55);
    #1;
    chk("r0_ready", 64'(bus.lt_ready), 64'd1);
    step();
    late(1'b0, 5'd0, 32'h0);
    #1;
    chk("r0_pend", 64'(pend_mask), 64'd0);
    step();
    step();

    // same-cycle push and pipeline write to r9
    late(1'b1, 5'd9, 32'h1);
    wb(1'b1, 5'd9, 32'h2);
    expw(5'd9, 32'h2);
    step();
    late(1'b0, 5'd0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("r9_pend", 64'(pend_mask), 64'd0);
    step();
    step();

    // reset with two live entries discards them
    wb(1'b1, 5'd1, 32'h201);
    late(1'b1, 5'd12, 32'hC);
    expw(5'd1, 32'h201);
    step();
    wb(1'b1, 5'd2, 32'h202);
    late(1'b1, 5'd13, 32'hD);
    expw(5'd2, 32'h202);
    step();
    late(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("pend_12_13", 64'(pend_mask), 64'h3000);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_pend", 64'(pend_mask), 64'd0);
    chk("post_rst_ready", 64'(bus.lt_ready), 64'd1);
    step();
    step();
    step();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-port arbiter for the integer register file. It merges two sources into the register file's single write port (`we`/`waddr`/`wdata`). The first is the in-order pipeline write-back, which has fixed priority and is never stalled. The second is a long-latency unit (divider, late load), whose results are buffered in a small FIFO and drained into idle write slots. It also tracks registers with pending late writes for decode interlock, and kills stale late results that a younger pipeline write has superseded.

## Interface
Parameters:
- `DEPTH`, 2: late-result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: cycles a live FIFO head may wait before `stall_req` is raised.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable`).
- `wb_we`  in  1  pipeline write-back enable.
- `wb_waddr`  in  `RegAddrBus`  pipeline destination.
- `wb_wdata`  in  `RegBus`  pipeline result.
- `lt_valid`  in  1  late unit has a result.
- `lt_ready`  out  1  FIFO can accept; transfer when `lt_valid && lt_ready`.
- `lt_waddr`  in  `RegAddrBus`  late destination.
- `lt_wdata`  in  `RegBus`  late result.
- `we`  out  1  to register file write enable.
- `waddr`  out  `RegAddrBus`  to register file.
- `wdata`  out  `RegBus`  to register file.
- `pend_mask`  out  `RegNum`  bit i set while a live FIFO entry targets register i.
- `stall_req`  out  1  request one pipeline write-back bubble.

## Operation
- Write-port mux is combinational. If `wb_we` is high, the output is the pipeline write. Otherwise, if the FIFO head is live, the output is the head and the head pops. Otherwise `we`=0, `waddr`=0, `wdata`=0.
- Push: on handshake, the entry is written with a live bit. An entry with `lt_waddr`==0 is accepted but stored dead. So is an entry whose address equals `wb_waddr` while `wb_we` is high in the same cycle; a late result is always older than a same-cycle pipeline write.
- Kill: every cycle with `wb_we`, all stored entries with address == `wb_waddr` have their live bit cleared.
- A dead head pops every cycle regardless of `wb_we` and never asserts `we`.
- A live head pops only in a cycle where `wb_we`=0.
- `lt_ready` = not full, using registered occupancy. No same-cycle pop-then-push credit.
- `pend_mask` is the OR over live entries of their address decode. It is registered, so it reflects state after the last edge.
- Starvation counter: clears when the head pops or the FIFO is empty. Otherwise it increments while `wb_we` blocks a live head, saturating at `STARVE_LIMIT`. `stall_req` is high while count == `STARVE_LIMIT`. The pipeline answers with a cycle of `wb_we`=0, the head drains, and the counter clears.

## Timing
- Pipeline path has zero latency. The pipeline write appears on `we`/`waddr`/`wdata` in the same cycle.
- Late path: a result accepted at edge N is written no earlier than cycle N+1, in FIFO order.
- Reset, held while `rst`=1 and effective at the edge:
  - FIFO empty, all live bits 0, counter 0.
  - `lt_ready`=0, `pend_mask`=0, `stall_req`=0.
  - `we`/`waddr`/`wdata` forced to 0 (combinational gate on `rst`).
- First cycle after reset: `lt_ready`=1.
- Reset mid-operation discards all buffered results without writing them.
- Pointers wrap modulo `DEPTH`. Occupancy is counted 0..`DEPTH`, giving full/empty without pointer ambiguity.
- Full FIFO with a dead head: that cycle's pop frees a slot, but `lt_ready` stays 0 until the next cycle.

## Structure
- `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `RstEnable`, `WriteEnable` and `ZeroWord` come from the shared `defines.v`.
- Add `LtFifoDepth` there as well.
- One sub-module is natural: `wr_arb_fifo`. It holds the storage, per-entry live bits, address-compare kill logic and occupancy. The top level keeps the mux, starvation counter and `pend_mask` reduction.

## Test plan
- Reset, then `wb_we`=1, `wb_waddr`=3, `wb_wdata`=0x11 → same cycle `we`=1, `waddr`=3, `wdata`=0x11. `lt_ready` is 0 during reset and 1 on the cycle after reset deasserts.
- Late push (5, 0xAA) with pipeline idle → `we`=1, `waddr`=5, `wdata`=0xAA next cycle. `pend_mask[5]` is set for exactly one cycle.
- Push (7, 0xBB), then `wb_we` to r7 with 0xCC next cycle → r7 written once with 0xCC. 0xBB is never written and `pend_mask[7]` clears.
- Push 2 entries while `wb_we` is held high → `lt_ready`=0. After 8 blocked cycles `stall_req`=1. One idle cycle writes the head and clears `stall_req`.
- Push with `lt_waddr`=0 → accepted, no write ever, `pend_mask`=0.
- Same-cycle push (9, 0x1) and `wb_we` to r9 (0x2) → only 0x2 written. Assert `rst` with 2 live entries → no writes afterwards, `pend_mask`=0.
